// File: rtl/mips_cpu_alu_regfile.sv
// Multicycle MIPS datapath core: 32x32 register file (2 comb reads, 1 sync write) plus comb ALU.
// Reads and ALU are zero-latency; writes land on the rising edge; no backpressure.
module mips_cpu_alu_regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic        writeEnable,
  input  logic [4:0]  writeaddress,
  input  logic [31:0] dataIn,
  input  logic [4:0]  readAddressA,
  output logic [31:0] readDataA,
  input  logic [4:0]  readAddressB,
  output logic [31:0] readDataB,
  output logic [31:0] register_v0,
  input  logic [3:0]  control,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  sa,
  output logic [31:0] r,
  output logic        zero
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_SLLV = 4'b1011;
  localparam logic [3:0] OP_SRLV = 4'b1100;
  localparam logic [3:0] OP_SRAV = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  logic [31:0][31:0] regs_q;
  logic [31:0][31:0] regs_d;

  // Index 0 is forced to zero so $zero can never hold a written value.
  always_comb begin
    regs_d = regs_q;
    if (writeEnable && (writeaddress != 5'd0)) begin
      regs_d[writeaddress] = dataIn;
    end
    regs_d[0] = 32'h0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign readDataA   = regs_q[readAddressA];
  assign readDataB   = regs_q[readAddressB];
  assign register_v0 = regs_q[2];

  always_comb begin
    r = 32'h0;
    unique case (control)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {31'h0, ($signed(a) < $signed(b))};
      OP_SLTU: r = {31'h0, (a < b)};
      OP_SLL:  r = b << sa;
      OP_SRL:  r = b >> sa;
      OP_SRA:  r = $signed(b) >>> sa;
      OP_SLLV: r = b << a[4:0];
      OP_SRLV: r = b >> a[4:0];
      OP_SRAV: r = $signed(b) >>> a[4:0];
      OP_LUI:  r = {b[15:0], 16'h0};
      default: r = 32'h0;
    endcase
  end

  assign zero = (r == 32'h0);

endmodule

// File: tb/tb_mips_cpu_alu_regfile.sv
// Directed bench for mips_cpu_alu_regfile: expected values queued at drive time, popped at check time.
module tb_mips_cpu_alu_regfile;

  logic        clk;
  logic        reset;
  logic        writeEnable;
  logic [4:0]  writeaddress;
  logic [31:0] dataIn;
  logic [4:0]  readAddressA;
  logic [31:0] readDataA;
  logic [4:0]  readAddressB;
  logic [31:0] readDataB;
  logic [31:0] register_v0;
  logic [3:0]  control;
  logic [31:0] a;
  logic [31:0] b;
  logic [4:0]  sa;
  logic [31:0] r;
  logic        zero;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  mips_cpu_alu_regfile dut (
    .clk(clk), .reset(reset),
    .writeEnable(writeEnable), .writeaddress(writeaddress), .dataIn(dataIn),
    .readAddressA(readAddressA), .readDataA(readDataA),
    .readAddressB(readAddressB), .readDataB(readDataB),
    .register_v0(register_v0),
    .control(control), .a(a), .b(b), .sa(sa), .r(r), .zero(zero)
  );

  // Clock is held low for the first 50 time units so reset can be checked with no edge.
  initial begin
    clk = 1'b0;
    #50;
    forever #5 clk = ~clk;
  end

  task automatic push(input string t, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_underflow: observed %h with nothing expected", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  // Drive a write, let the next rising edge take it, then drop the strobe.
  task automatic wr(input logic we, input logic [4:0] addr, input logic [31:0] d);
    writeEnable = we; writeaddress = addr; dataIn = d;
    @(posedge clk);
    #2;
    writeEnable = 1'b0;
  endtask

  task automatic alu(input string t, input logic [3:0] c, input logic [31:0] av,
                     input logic [31:0] bv, input logic [4:0] s,
                     input logic [31:0] er, input logic ez);
    control = c; a = av; b = bv; sa = s;
    push({t, "_r"}, er);
    push({t, "_zero"}, {31'h0, ez});
    #1;
    pop_check(r);
    pop_check({31'h0, zero});
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [31:0] v;
    v = (32'h0101_0101 * i) ^ 32'hA5A5_0000;
    return v;
  endfunction

  initial begin
    reset = 1'b1; writeEnable = 1'b0; writeaddress = '0; dataIn = '0;
    readAddressA = '0; readAddressB = '0;
    control = 4'b1111; a = '0; b = '0; sa = '0;
    #1;
    reset = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) begin
      readAddressA = i[4:0]; readAddressB = 5'(31 - i);
      push("reset_rdA", 32'h0);
      push("reset_rdB", 32'h0);
      #1;
      pop_check(readDataA);
      pop_check(readDataB);
    end
    push("reset_v0", 32'h0);
    pop_check(register_v0);

    #5 reset = 1'b1;
    @(posedge clk); #2;
    wr(1'b0, 5'd2, 32'hCAFE_F00D);
    readAddressA = 5'd2;
    push("we0_rdA", 32'h0);
    push("we0_v0", 32'h0);
    #1;
    pop_check(readDataA);
    pop_check(register_v0);

    wr(1'b1, 5'd2, 32'hDEAD_BEEF);
    wr(1'b1, 5'd31, 32'h0000_0005);
    readAddressA = 5'd31; readAddressB = 5'd2;
    push("wr_v0", 32'hDEAD_BEEF);
    push("wr_rdA31", 32'h0000_0005);
    push("wr_rdB2", 32'hDEAD_BEEF);
    #1;
    pop_check(register_v0);
    pop_check(readDataA);
    pop_check(readDataB);

    wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    readAddressA = 5'd0;
    push("zero_reg", 32'h0);
    #1;
    pop_check(readDataA);

    wr(1'b1, 5'd3, 32'h1111_1111);
    writeEnable = 1'b1; writeaddress = 5'd3; dataIn = 32'h3333_3333;
    readAddressA = 5'd3; readAddressB = 5'd3;
    push("bypass_old_A", 32'h1111_1111);
    push("bypass_old_B", 32'h1111_1111);
    #1;
    pop_check(readDataA);
    pop_check(readDataB);
    @(posedge clk); #2;
    writeEnable = 1'b0;
    push("bypass_new_A", 32'h3333_3333);
    push("bypass_new_B", 32'h3333_3333);
    pop_check(readDataA);
    pop_check(readDataB);

    // Fill every register then read all back on both ports.
    for (int i = 1; i < 32; i++) wr(1'b1, i[4:0], pat(i));
    wr(1'b0, 5'd7, 32'h0BAD_0BAD);
    for (int i = 0; i < 32; i++) begin
      readAddressA = i[4:0]; readAddressB = 5'(31 - i);
      push("fill_rdA", (i == 0) ? 32'h0 : pat(i));
      push("fill_rdB", (i == 31) ? 32'h0 : pat(31 - i));
      #1;
      pop_check(readDataA);
      pop_check(readDataB);
    end
    push("fill_v0", pat(2));
    pop_check(register_v0);

    // Mid-cycle reset must clear with no clock edge.
    readAddressA = 5'd9; readAddressB = 5'd31;
    reset = 1'b0;
    push("async_rst_A", 32'h0);
    push("async_rst_B", 32'h0);
    push("async_rst_v0", 32'h0);
    #1;
    pop_check(readDataA);
    pop_check(readDataB);
    pop_check(register_v0);
    wr(1'b1, 5'd9, 32'h9999_9999);
    push("rst_wins_A", 32'h0);
    pop_check(readDataA);
    reset = 1'b1;
    wr(1'b1, 5'd9, 32'h9999_9999);
    push("post_rst_wr", 32'h9999_9999);
    pop_check(readDataA);

    alu("add_wrap",  4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1);
    alu("add_addr",  4'b0100, 32'hBFC0_0000, 32'hFFFF_FFFC, 5'd0, 32'hBFBF_FFFC, 1'b0);
    alu("add_small", 4'b0100, 32'h0000_0F0F, 32'h0000_00FF, 5'd0, 32'h0000_100E, 1'b0);
    alu("sub_neg",   4'b0101, 32'h0000_0005, 32'h0000_0007, 5'd0, 32'hFFFF_FFFE, 1'b0);
    alu("and",       4'b0000, 32'h0000_0F0F, 32'h0000_00FF, 5'd0, 32'h0000_000F, 1'b0);
    alu("or",        4'b0001, 32'h0000_0F0F, 32'h0000_00FF, 5'd0, 32'h0000_0FFF, 1'b0);
    alu("xor",       4'b0010, 32'h0000_0F0F, 32'h0000_00FF, 5'd0, 32'h0000_0FF0, 1'b0);
    alu("nor",       4'b0011, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF, 1'b0);
    alu("slt_neg",   4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001, 1'b0);
    alu("sltu_big",  4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0000, 1'b1);
    alu("slt_pos",   4'b0110, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b1);
    alu("sltu_small",4'b0111, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0001, 1'b0);
    alu("lui",       4'b1110, 32'h0000_0000, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0);
    alu("default",   4'b1111, 32'h1234_5678, 32'h8765_4321, 5'd3, 32'h0000_0000, 1'b1);
    alu("sra",       4'b1010, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0);
    alu("srl",       4'b1001, 32'h0000_0000, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0);
    alu("sll",       4'b1000, 32'h0000_0000, 32'h8000_0001, 5'd1, 32'h0000_0002, 1'b0);
    alu("sll31",     4'b1000, 32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0);
    alu("sllv",      4'b1011, 32'h0000_0021, 32'h0000_0001, 5'd7, 32'h0000_0002, 1'b0);
    alu("srlv",      4'b1100, 32'h0000_0024, 32'hF000_0000, 5'd0, 32'h0F00_0000, 1'b0);
    alu("srav",      4'b1101, 32'h0000_0024, 32'hF000_0000, 5'd0, 32'hFF00_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
